// File: rtl/fsk_pkg.sv
// fsk_pkg: shared definitions for the FSK bit framer and the future bit deframer.
//   - fsk_state_e  : framer/deframer state encoding (3-bit)
//   - FRAME_DATA_BITS : data bits per asynchronous-serial frame
//   - BIT_TIMER_W  : width of the per-bit down-counter
//   - DATA_IDX_W   : width of the data-bit index
package fsk_pkg;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam int unsigned BIT_TIMER_W     = 16;
  localparam int unsigned DATA_IDX_W      = $clog2(FRAME_DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } fsk_state_e;

endpackage

// File: rtl/fsk_bit_timer.sv
// fsk_bit_timer: loadable down-counter that marks the last clock of a bit period.
// Ports:
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-high reset (count -> 0)
//   load     in  load load_val on the next edge (takes priority over counting)
//   load_val in  value to load, normally bit period minus one
//   tick     out high while the count is zero
// The counter holds at zero until reloaded.
module fsk_bit_timer
  import fsk_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [BIT_TIMER_W-1:0] load_val,
  output logic                   tick
);

  logic [BIT_TIMER_W-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign tick = (count_q == '0);

endmodule

// File: rtl/fsk_bit_framer.sv
// fsk_bit_framer: turns bytes into an asynchronous-serial bitstream for the FSK modulator.
// Frame: start(0), 8 data bits LSB first, optional parity, stop(1); each bit lasts
// BIT_CYCLES clocks. The idle line is mark (1).
// Optional feature: define FSK_FRAMER_PARITY_EN to insert a parity bit (PARITY_ODD picks sense).
// Ports:
//   clk        in  clock, rising edge
//   rst        in  asynchronous active-high reset
//   in_data    in  byte to transmit, captured on the transfer edge
//   in_valid   in  in_data is valid
//   in_ready   out registered, high while idle
//   data_out   out registered serial bit to the modulator
//   busy       out registered, high while a frame is in progress
//   frame_done out one-clock pulse on the last clock of the stop bit
module fsk_bit_framer
  import fsk_pkg::*;
#(
  parameter int unsigned BIT_CYCLES = 400,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       data_out,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [BIT_TIMER_W-1:0] BitLoad = BIT_TIMER_W'(BIT_CYCLES - 1);

  fsk_state_e            state_q, state_d;
  logic [7:0]            shift_q, shift_d;
  logic [DATA_IDX_W-1:0] idx_q, idx_d;
  logic                  in_ready_q, busy_q, data_out_q;
  logic                  data_out_d;
  logic                  timer_load;
  logic                  tick;
  logic                  xfer;

  assign xfer = in_valid && in_ready_q;

`ifdef FSK_FRAMER_PARITY_EN
  // Parity of the whole byte, latched at capture since the shift register is consumed.
  logic parity_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if (xfer) begin
      parity_q <= ^in_data;
    end
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = PARITY_ODD;
`endif

  fsk_bit_timer u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (BitLoad),
    .tick     (tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    timer_load = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          state_d    = ST_START;
          shift_d    = in_data;
          timer_load = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d    = ST_DATA;
          idx_d      = '0;
          timer_load = 1'b1;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 1'b1;  // wraps 7 -> 0 on the last data bit
          if (idx_q == DATA_IDX_W'(FRAME_DATA_BITS - 1)) begin
`ifdef FSK_FRAMER_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
          timer_load = 1'b1;
        end
      end
`ifdef FSK_FRAMER_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          timer_load = 1'b1;
        end
      end
`endif
      ST_STOP: begin
        // Timer is left at zero on return to idle; the next transfer reloads it.
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // The serial bit is registered, so it is derived from the next state.
  always_comb begin
    data_out_d = 1'b1;
    unique case (state_d)
      ST_START: data_out_d = 1'b0;
      ST_DATA:  data_out_d = shift_d[0];
`ifdef FSK_FRAMER_PARITY_EN
      ST_PARITY: data_out_d = parity_q ^ PARITY_ODD;
`endif
      default:  data_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      idx_q      <= '0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      data_out_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      in_ready_q <= (state_d == ST_IDLE);
      busy_q     <= (state_d != ST_IDLE);
      data_out_q <= data_out_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign data_out   = data_out_q;
  assign frame_done = (state_q == ST_STOP) && tick;

endmodule

// File: tb/tb_fsk_bit_framer.sv
// Self-checking bench for fsk_bit_framer: a BIT_CYCLES=4 instance for most scenarios and a
// BIT_CYCLES=1 instance for the single-clock-bit case. Expected per-clock line levels are
// pushed to a queue at each transfer and popped as the frame is observed.
module tb_fsk_bit_framer;

  localparam int BC = 4;
`ifdef FSK_FRAMER_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CLKS = FRAME_BITS * BC;
  localparam int WAIT_LIMIT = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data, in_data1;
  logic       in_valid, in_valid1;
  logic       in_ready, data_out, busy, frame_done;
  logic       in_ready1, data_out1, busy1, frame_done1;

  int checks = 0;
  int errors = 0;
  int xfers  = 0;
  logic exp_q[$];
  logic exp1_q[$];

  always #5 clk = ~clk;

  fsk_bit_framer #(.BIT_CYCLES(BC), .PARITY_ODD(1'b0)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data_out   (data_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  fsk_bit_framer #(.BIT_CYCLES(1), .PARITY_ODD(1'b0)) u_dut1 (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data1),
    .in_valid   (in_valid1),
    .in_ready   (in_ready1),
    .data_out   (data_out1),
    .busy       (busy1),
    .frame_done (frame_done1)
  );

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) xfers <= xfers + 1;
  end

  // Reference frame: bit k of the result is the k-th bit on the line.
  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef FSK_FRAMER_PARITY_EN
    f[9] = ^b;  // even parity
`endif
    return f;
  endfunction

  // Called at a negedge; runs one frame on u_dut and checks it clock by clock.
  task automatic run_frame(input logic [7:0] b, input bit hold_valid, input bit stall_mid,
                           input string tag);
    logic [10:0] f;
    logic        exp;
    int          n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL %s_accept: in_ready=%b after %0d clocks, required 1", tag, in_ready, n);
      in_valid = 1'b0;
      return;
    end
    f = frame_bits(b);
    for (int k = 0; k < FRAME_BITS; k++)
      for (int j = 0; j < BC; j++) exp_q.push_back(f[k]);
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    for (int c = 1; c <= FRAME_CLKS; c++) begin
      exp = exp_q.pop_front();
      checks++;
      if (data_out !== exp) begin
        errors++;
        $display("FAIL %s_bit clk%0d: data_out=%b required %b", tag, c, data_out, exp);
      end
      checks++;
      if (frame_done !== (c == FRAME_CLKS)) begin
        errors++;
        $display("FAIL %s_done clk%0d: frame_done=%b required %b", tag, c, frame_done,
                 (c == FRAME_CLKS));
      end
      if (c == 1 || c == FRAME_CLKS) begin
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s_busy clk%0d: busy=%b in_ready=%b required 1/0", tag, c, busy,
                   in_ready);
        end
      end
      if (stall_mid && c == FRAME_CLKS / 2) begin
        in_valid = 1'b1;
        in_data  = ~b;
      end
      if (stall_mid && c == FRAME_CLKS / 2 + 1) in_valid = 1'b0;
      if (c != FRAME_CLKS) @(negedge clk);
    end
  endtask

  // Checks the single mark clock that follows a stop bit.
  task automatic check_gap(input string tag);
    @(negedge clk);
    checks++;
    if (data_out !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_gap: data_out=%b in_ready=%b busy=%b frame_done=%b required 1/1/0/0",
               tag, data_out, in_ready, busy, frame_done);
    end
  endtask

  task automatic test_reset;
    int n;
    bit saw_done;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (data_out !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: data_out=%b in_ready=%b busy=%b frame_done=%b required 1/1/0/0",
               data_out, in_ready, busy, frame_done);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    // Start a frame, then reset in the middle of the data bits.
    in_data  = 8'hC3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3 * BC) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: busy=%b required 1", busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (data_out !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: data_out=%b in_ready=%b busy=%b frame_done=%b required 1/1/0/0",
               data_out, in_ready, busy, frame_done);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    n = 0;
    repeat (FRAME_CLKS + 8) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || data_out !== 1'b1) saw_done = 1'b1;
      n++;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL reset_abandon: frame activity seen after reset in %0d clocks, required none",
               n);
    end
    exp_q.delete();
  endtask

  task automatic test_single_byte;
    run_frame(8'hA5, 1'b0, 1'b0, "a5");
    check_gap("a5");
  endtask

  task automatic test_back_to_back;
    int x0;
    x0 = xfers;
    run_frame(8'h00, 1'b1, 1'b0, "b2b0");
    check_gap("b2b0");
    run_frame(8'hFF, 1'b0, 1'b0, "b2b1");
    check_gap("b2b1");
    checks++;
    if (xfers - x0 !== 2) begin
      errors++;
      $display("FAIL b2b_count: transfers=%0d required 2", xfers - x0);
    end
  endtask

  task automatic test_stall;
    int x0;
    x0 = xfers;
    run_frame(8'h5A, 1'b0, 1'b1, "stall");
    check_gap("stall");
    checks++;
    if (xfers - x0 !== 1) begin
      errors++;
      $display("FAIL stall_count: transfers=%0d required 1", xfers - x0);
    end
  endtask

`ifdef FSK_FRAMER_PARITY_EN
  task automatic test_parity;
    int n;
    in_data  = 8'h07;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    // Middle of bit index 9.
    repeat (9 * BC + BC / 2) @(negedge clk);
    checks++;
    if (data_out !== 1'b1) begin
      errors++;
      $display("FAIL parity_bit: data_out=%b required 1", data_out);
    end
    repeat (FRAME_CLKS - (9 * BC + BC / 2) - 1) @(negedge clk);
    checks++;
    if (frame_done !== 1'b1) begin
      errors++;
      $display("FAIL parity_len: frame_done=%b at clock %0d required 1", frame_done, FRAME_CLKS);
    end
    check_gap("parity");
  endtask
`endif

  task automatic test_bit_cycles_one;
    logic [10:0] f;
    logic        exp;
    int          n;
    in_data1  = 8'h3C;
    in_valid1 = 1'b1;
    n = 0;
    while (!in_ready1 && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    f = frame_bits(8'h3C);
    for (int k = 0; k < FRAME_BITS; k++) exp1_q.push_back(f[k]);
    @(negedge clk);
    in_valid1 = 1'b0;
    for (int c = 1; c <= FRAME_BITS; c++) begin
      exp = exp1_q.pop_front();
      checks++;
      if (data_out1 !== exp || frame_done1 !== (c == FRAME_BITS)) begin
        errors++;
        $display("FAIL bc1 clk%0d: data_out=%b frame_done=%b required %b/%b", c, data_out1,
                 frame_done1, exp, (c == FRAME_BITS));
      end
      if (c != FRAME_BITS) @(negedge clk);
    end
    @(negedge clk);
    checks++;
    if (in_ready1 !== 1'b1 || busy1 !== 1'b0 || data_out1 !== 1'b1) begin
      errors++;
      $display("FAIL bc1_gap: in_ready=%b busy=%b data_out=%b required 1/0/1", in_ready1, busy1,
               data_out1);
    end
  endtask

  initial begin
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_data1  = 8'h00;
    in_valid1 = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_stall();
`ifdef FSK_FRAMER_PARITY_EN
    test_parity();
`endif
    test_bit_cycles_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
